uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
//
// PURPOSE
// - Configurable UART transmitter: serialises one 5..8-bit word per request as
//   start + LSB-first payload + optional parity + 1 or 2 stop bits.
// - Drop-in successor for the fixed 8N1 transmitter: same accept handshake, plus
//   per-frame completion pulse and compile-time frame format.
// - Sits between a byte producer (FIFO, CPU register) and the uart_txd pad.
//
// PARAMETERS
// - BIT_RATE      9600       line bit rate, bits/s
// - CLK_HZ        100000000  clk frequency, Hz
// - PAYLOAD_BITS  8          data bits per frame, legal 5..8
// - STOP_BITS     1          stop bits per frame, legal 1..2
// - PARITY_ODD    0          0 = even parity, 1 = odd; used only with UART_TX_PARITY_EN
// - Derived: CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide, must be >= 2).
//   Counter width = $clog2(CYCLES_PER_BIT); no 8-bit cap.
// - An illegal value is a configuration error: simulation prints an error and calls $finish.
//
// PORTS
// - clk        in   1  system clock
// - resetn     in   1  asynchronous active-low reset
// - uart_txd   out  1  serial line, idle high, registered
// - tx_busy    out  1  high while a frame is in flight
// - tx_enable  in   1  request to send tx_data
// - tx_data    in   8  word to send; bits [PAYLOAD_BITS-1:0] used, upper bits ignored
// - tx_done    out  1  one-cycle pulse when the last stop bit completes
//
// BEHAVIOUR
// - Reset (async, any state): uart_txd=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0,
//   data register=0.
// - States: IDLE, START, DATA, PARITY, STOP.
//   tx_busy = (state != IDLE), decoded from the state register.
// - Accept: on an edge where tx_enable=1 and tx_busy=0:
//   - capture tx_data;
//   - go to START;
//   - drive uart_txd=0 from that edge.
//   tx_enable while tx_busy=1 is ignored and does not alter the frame in flight.
// - Each line bit is held for exactly CYCLES_PER_BIT cycles. The cycle counter resets
//   on every bit boundary.
// - START -> DATA after 1 bit time.
// - DATA sends bit index 0..PAYLOAD_BITS-1, LSB first. After index PAYLOAD_BITS-1:
//   - go to PARITY if parity is enabled;
//   - otherwise go to STOP.
// - PARITY: 1 bit time, then STOP.
// - STOP: uart_txd=1 for STOP_BITS bit times, then IDLE.
//   - tx_done=1 on the same edge that enters IDLE.
// - Frame length = (1 + PAYLOAD_BITS + P + STOP_BITS) * CYCLES_PER_BIT cycles from the
//   accept edge to the tx_busy fall. P = 1 with parity, else 0.
// - Back-to-back: tx_busy is low for at least 1 cycle between frames, so the line idles
//   high for at least 1 cycle. A tx_enable held high is accepted at that cycle.
// - uart_txd only changes on bit boundaries. The line never glitches mid-bit.
//
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state is present;
//   - parity bit = ^payload XOR PARITY_ODD, computed over PAYLOAD_BITS bits only.
// - UART_TX_PARITY_EN undefined:
//   - no PARITY state and no parity logic;
//   - PARITY_ODD is ignored;
//   - frame = start + payload + stop.
//
// TESTING  (CLK_HZ=50, BIT_RATE=5 -> 10 cycles/bit unless stated)
// - Reset: hold resetn=0 -> uart_txd=1, tx_busy=0, tx_done=0.
//   Release, 20 idle cycles -> line stays 1.
// - 8N1, send 0xA5 -> line 0|1,0,1,0,0,1,0,1|1, 10 cycles each.
//   tx_busy high 100 cycles. Exactly one tx_done pulse.
// - PAYLOAD_BITS=5, STOP_BITS=2, send 0xFF -> 0|1,1,1,1,1|1,1.
//   tx_busy high 80 cycles. Bits 7:5 are never transmitted.
// - UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 110 cycles.
//   PARITY_ODD=1, same data -> parity bit 0.
// - Send 0x3C, then hold tx_enable with tx_data=0xC3 during the frame -> 0x3C sent intact.
//   0xC3 accepted 1 cycle after tx_busy falls.
// - Assert resetn=0 mid DATA bit 3 -> uart_txd=1 and tx_busy=0 immediately.
//   After release, send 0x55 -> correct 0x55 frame.
// - CYCLES_PER_BIT=868 (100 MHz / 115200) -> each bit exactly 868 cycles; counter does not wrap.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
// uart_tx_cfg
//
// Configurable UART transmitter. Each accepted request is serialised as
// start bit + PAYLOAD_BITS data bits (LSB first) + optional parity bit +
// STOP_BITS stop bits. Every line bit lasts CLK_HZ/BIT_RATE clock cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the payload
//                (even parity, or odd when PARITY_ODD=1)
//   undefined -> no parity state or logic; PARITY_ODD is ignored
//
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   uart_txd   out  serial line, idle high, driven from a register
//   tx_busy    out  high while a frame is in flight
//   tx_enable  in   request to send tx_data (taken only while tx_busy=0)
//   tx_data    in   word to send; only bits [PAYLOAD_BITS-1:0] go on the line
//   tx_done    out  one-cycle pulse on the edge that ends the last stop bit
//
// FSM
//   state   | meaning
//   IDLE    | line high, waiting for tx_enable
//   START   | start bit (line low)
//   DATA    | payload bit r_bit_idx on the line
//   PARITY  | parity bit on the line (UART_TX_PARITY_EN only)
//   STOP    | stop bit r_stop_idx on the line (line high)

module uart_tx_cfg #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       uart_txd,
  output logic       tx_busy,
  input  logic       tx_enable,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  // Wide enough for CYCLES_PER_BIT-1 at any bit rate; the floor of 1 only
  // keeps elaboration alive long enough for the configuration check to fire.
  localparam int CNT_W = (CYCLES_PER_BIT >= 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(PAYLOAD_BITS - 1);
  localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Configuration errors stop elaboration with a message.
  if (CYCLES_PER_BIT < 2) begin : g_bad_rate
    $fatal(1, "uart_tx_cfg: CLK_HZ/BIT_RATE must be >= 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : g_bad_payload
    $fatal(1, "uart_tx_cfg: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $fatal(1, "uart_tx_cfg: PARITY_ODD must be 0 or 1");
  end

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_stop_idx;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             r_done;
  logic             w_cnt_tc;

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] PAYLOAD_MASK = 8'((1 << PAYLOAD_BITS) - 1);
  logic r_parity;
  logic w_parity;
  // Parity covers only the transmitted payload bits, never the ignored upper bits.
  assign w_parity = (^(tx_data & PAYLOAD_MASK)) ^ (PARITY_ODD != 0);
`endif

  // Down-counter reaches zero on the last cycle of every line bit.
  assign w_cnt_tc = (r_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (tx_enable) begin
          r_state <= S_START;
          r_txd   <= 1'b0;
          r_cnt   <= CNT_RELOAD;
          r_shift <= tx_data;
`ifdef UART_TX_PARITY_EN
          r_parity <= w_parity;
`endif
        end
      end else if (!w_cnt_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        // Bit boundary: every line change happens only here.
        r_cnt <= CNT_RELOAD;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
          S_DATA: begin
            if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= r_parity;
`else
              r_state    <= S_STOP;
              r_stop_idx <= 1'b0;
              r_txd      <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b1;
          end
`endif
          S_STOP: begin
            if (r_stop_idx == LAST_STOP) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign uart_txd = r_txd;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
// Three transmitters: 8-bit/1-stop and 5-bit/2-stop at 10 cycles per bit, and
// 8-bit/1-stop at 100 MHz / 115200 (868 cycles per bit). Expected frames are
// queued by the stimulus; a monitor pops one entry whenever a frame starts.

module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CPB   [3] = '{10, 10, 868};
  localparam int PB    [3] = '{8, 5, 8};
  localparam int STOPB [3] = '{1, 2, 1};
  localparam int ODD   [3] = '{0, 1, 0};

  typedef struct {
    int          d;
    logic [15:0] bits;
    int          n;
    bit          abort;
  } exp_t;

  logic       clk;
  logic [2:0] rstn;
  logic [2:0] en;
  logic [7:0] data [3];
  wire  [2:0] w_line;
  wire  [2:0] w_busy;
  wire  [2:0] w_done;

  int   checks;
  int   errors;
  exp_t sbq[$];
  bit   mon_active;

  uart_tx_cfg #(.BIT_RATE(5), .CLK_HZ(50), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .resetn(rstn[0]), .uart_txd(w_line[0]), .tx_busy(w_busy[0]),
    .tx_enable(en[0]), .tx_data(data[0]), .tx_done(w_done[0]));

  uart_tx_cfg #(.BIT_RATE(5), .CLK_HZ(50), .PAYLOAD_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .resetn(rstn[1]), .uart_txd(w_line[1]), .tx_busy(w_busy[1]),
    .tx_enable(en[1]), .tx_data(data[1]), .tx_done(w_done[1]));

  uart_tx_cfg #(.BIT_RATE(115200), .CLK_HZ(100000000), .PAYLOAD_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .resetn(rstn[2]), .uart_txd(w_line[2]), .tx_busy(w_busy[2]),
    .tx_enable(en[2]), .tx_data(data[2]), .tx_done(w_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line levels in transmission order: start, payload LSB first, parity, stops.
  function automatic exp_t build(input int d, input logic [7:0] v);
    exp_t e;
    logic p;
    e.d = d; e.bits = '1; e.abort = 1'b0;
    e.bits[0] = 1'b0;
    e.n = 1;
    p = (ODD[d] != 0);
    for (int i = 0; i < PB[d]; i++) begin
      e.bits[e.n] = v[i];
      p = p ^ v[i];
      e.n++;
    end
    if (PAR_EN) begin
      e.bits[e.n] = p;
      e.n++;
    end
    for (int s = 0; s < STOPB[d]; s++) begin
      e.bits[e.n] = 1'b1;
      e.n++;
    end
    return e;
  endfunction

  task automatic check_frame(input int d);
    exp_t e;
    int   done_cnt;
    bit   busy_ok;
    bit   bad;
    bit   first;
    logic act;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_frame dut%0d: frame started, none queued", d);
      for (int k = 0; k < 20000 && w_busy[d] === 1'b1; k++) @(negedge clk);
      return;
    end
    e = sbq.pop_front();
    checks++;
    if (e.d != d) begin
      errors++;
      $display("FAIL frame_owner: frame on dut%0d, expected dut%0d", d, e.d);
    end
    if (e.abort) begin
      for (int k = 0; k < 5000 && w_busy[d] === 1'b1; k++) @(negedge clk);
      return;
    end
    done_cnt = 0; busy_ok = 1'b1; first = 1'b1;
    for (int b = 0; b < e.n; b++) begin
      bad = 1'b0; act = e.bits[b];
      for (int c = 0; c < CPB[d]; c++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        if (w_busy[d] !== 1'b1) busy_ok = 1'b0;
        if (w_done[d] === 1'b1) done_cnt++;
        if (w_line[d] !== e.bits[b] && !bad) begin
          bad = 1'b1; act = w_line[d];
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL line_bit dut%0d bit%0d: got %b want %b", d, b, act, e.bits[b]);
      end
    end
    @(negedge clk);
    if (w_done[d] === 1'b1) done_cnt++;
    checks++;
    if (!busy_ok || w_busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL busy_len dut%0d: busy_ok=%0b busy_after=%b want %0d cycles",
               d, busy_ok, w_busy[d], e.n * CPB[d]);
    end
    checks++;
    if (done_cnt != 1 || w_done[d] !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse dut%0d: pulses=%0d done_at_end=%b want 1 pulse at end",
               d, done_cnt, w_done[d]);
    end
    checks++;
    if (w_line[d] !== 1'b1) begin
      errors++;
      $display("FAIL idle_line dut%0d: got %b want 1", d, w_line[d]);
    end
  endtask

  // Monitor: a frame begins on the first negedge that sees tx_busy high.
  initial begin
    logic [2:0] prev;
    prev = '0;
    mon_active = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (w_busy[d] === 1'b1 && !prev[d]) begin
          mon_active = 1'b1;
          check_frame(d);
          mon_active = 1'b0;
        end
      end
      prev = w_busy;
    end
  end

  task automatic send(input int d, input logic [7:0] v);
    sbq.push_back(build(d, v));
    @(negedge clk);
    en[d] = 1'b1; data[d] = v;
    @(negedge clk);
    en[d] = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while ((sbq.size() != 0 || mon_active || w_busy != '0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) begin
      checks++; errors++;
      $display("FAIL drain_timeout: queue=%0d busy=%b", sbq.size(), w_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ab;
    bit   stayed;
    int   k;
    checks = 0; errors = 0;
    rstn = '0; en = '0;
    for (int d = 0; d < 3; d++) data[d] = 8'h00;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (w_line[d] !== 1'b1 || w_busy[d] !== 1'b0 || w_done[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: txd=%b busy=%b done=%b want 1 0 0",
                 d, w_line[d], w_busy[d], w_done[d]);
      end
    end
    rstn = '1;
    stayed = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (w_line[0] !== 1'b1 || w_busy[0] !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin
      errors++;
      $display("FAIL idle_after_reset: line left 1 or busy rose with no request");
    end

    // 8N1 0xA5: 0|1,0,1,0,0,1,0,1|1
    send(0, 8'hA5);
    wait_drain(400);
    // 5-bit, 2 stop: 0xFF -> all ones payload; 0xE0 -> bits 7:5 must not appear
    send(1, 8'hFF);
    wait_drain(400);
    send(1, 8'hE0);
    wait_drain(400);
    // 0x07 on both formats (parity 1 even / 0 odd when parity is built in)
    send(0, 8'h07);
    wait_drain(400);
    send(1, 8'h07);
    wait_drain(400);

    // tx_enable held with 0xC3 during the 0x3C frame
    sbq.push_back(build(0, 8'h3C));
    sbq.push_back(build(0, 8'hC3));
    @(negedge clk);
    en[0] = 1'b1; data[0] = 8'h3C;
    @(negedge clk);
    data[0] = 8'hC3;
    k = 0;
    while (w_busy[0] !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (w_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL held_accept_gap: busy=%b one cycle after fall, want 1", w_busy[0]);
    end
    en[0] = 1'b0;
    wait_drain(400);

    // Reset in the middle of payload bit 3 (cycles 40..49 after accept)
    ab.d = 0; ab.bits = '1; ab.n = 0; ab.abort = 1'b1;
    sbq.push_back(ab);
    @(negedge clk);
    en[0] = 1'b1; data[0] = 8'h55;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (43) @(negedge clk);
    #2 rstn[0] = 1'b0;
    #1;
    checks++;
    if (w_line[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: txd=%b busy=%b done=%b want 1 0 0",
               w_line[0], w_busy[0], w_done[0]);
    end
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h55);
    wait_drain(400);

    // 868 cycles per bit
    send(2, 8'h5A);
    wait_drain(12000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
